mips_reg_dump: RTL and testbench



---
 rtl/mips_dbg_pkg.sv | 12 +
 rtl/mips_reg_dump.sv | 89 ++++++++
 tb/tb_mips_reg_dump.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared widths and dump-engine state encoding for the MIPS debug readback logic.
package mips_dbg_pkg;
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;
    localparam int WORD_W    = 32;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/mips_reg_dump.sv
// mips_reg_dump: walks a register-file read port and streams each captured word over valid/ready.
module mips_reg_dump
    import mips_dbg_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [REG_IDX_W-1:0] rd_reg,
    input  logic [WORD_W-1:0]    rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic [REG_IDX_W-1:0] out_index,
    output logic                 out_last
);
    localparam int FIRST_IDX = (SKIP_ZERO && FIRST_REG == 0) ? 1 : FIRST_REG;
    localparam bit HAS_WORDS = FIRST_IDX <= LAST_REG;
    localparam logic [REG_IDX_W-1:0] FIRST_Q = REG_IDX_W'(FIRST_IDX);
    localparam logic [REG_IDX_W-1:0] LAST_Q  = REG_IDX_W'(LAST_REG);

    state_t                 state_q, state_d;
    logic [REG_IDX_W-1:0]   idx_q, idx_d, index_q, index_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic                   last_q, last_d, valid_q, valid_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        valid_d = valid_q;
        // done is a registered echo of FIN, so it never overlaps out_valid
        done_d  = state_q == FIN;
        case (state_q)
            IDLE: if (start) begin
                idx_d   = FIRST_Q;
                state_d = HAS_WORDS ? READ : FIN;
            end
            READ: begin
                data_d  = rd_data;
                index_d = idx_q;
                last_d  = idx_q == LAST_Q;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: if (out_ready) begin
                valid_d = 1'b0;
                state_d = last_q ? FIN : READ;
                idx_d   = last_q ? idx_q : idx_q + REG_IDX_W'(1);
            end
            FIN: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign rd_reg    = state_q == READ ? idx_q : '0;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = last_q;
endmodule

// File: tb/tb_mips_reg_dump.sv
// tb_mips_reg_dump: scoreboard bench for the register dump engine with three parameterisations.
module tb_mips_reg_dump;
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic ready_a = 1'b1;
    logic ready_bc = 1'b1;
    logic we = 1'b0, do_preload = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] regs [32];

    logic a_busy, a_done, a_valid, a_last, b_busy, b_done, b_valid, b_last, c_busy, c_done, c_valid, c_last;
    logic [4:0]  a_rd_reg, a_index, b_rd_reg, b_index, c_rd_reg, c_index;
    logic [31:0] a_data, b_data, c_data, a_rd_data, b_rd_data, c_rd_data;

    word_t q_a[$], q_b[$], q_c[$];
    word_t ea, eb, ec;
    int vectors = 0, errors = 0, viol = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + i;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign a_rd_data = regs[a_rd_reg];
    assign b_rd_data = regs[b_rd_reg];
    assign c_rd_data = regs[c_rd_reg];

    mips_reg_dump dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
        .rd_reg(a_rd_reg), .rd_data(a_rd_data), .out_valid(a_valid), .out_ready(ready_a),
        .out_data(a_data), .out_index(a_index), .out_last(a_last)
    );
    mips_reg_dump #(.FIRST_REG(8), .LAST_REG(8), .SKIP_ZERO(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
        .rd_reg(b_rd_reg), .rd_data(b_rd_data), .out_valid(b_valid), .out_ready(ready_bc),
        .out_data(b_data), .out_index(b_index), .out_last(b_last)
    );
    mips_reg_dump #(.FIRST_REG(0), .LAST_REG(0), .SKIP_ZERO(1'b1)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(c_busy), .done(c_done),
        .rd_reg(c_rd_reg), .rd_data(c_rd_data), .out_valid(c_valid), .out_ready(ready_bc),
        .out_data(c_data), .out_index(c_index), .out_last(c_last)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_word(input string name, input word_t e, input logic [4:0] idx,
                            input logic [31:0] data, input logic last);
        chk({name, "_index"}, 32'(idx), 32'(e.idx));
        chk({name, "_data"}, data, e.data);
        chk({name, "_last"}, 32'(last), 32'(e.last));
    endtask

    task automatic extra(input string name, input logic [4:0] idx);
        vectors++;
        errors++;
        $display("FAIL %s: unexpected word index %0d with no expectation queued", name, idx);
    endtask

    // monitors: every accepted word is popped and compared against the scoreboard
    always @(negedge clk) if (a_valid && ready_a) begin
        if (q_a.size() == 0) extra("a_extra", a_index);
        else begin ea = q_a.pop_front(); chk_word("a", ea, a_index, a_data, a_last); end
    end
    always @(negedge clk) if (b_valid && ready_bc) begin
        if (q_b.size() == 0) extra("b_extra", b_index);
        else begin eb = q_b.pop_front(); chk_word("b", eb, b_index, b_data, b_last); end
    end
    always @(negedge clk) if (c_valid && ready_bc) begin
        if (q_c.size() == 0) extra("c_extra", c_index);
        else begin ec = q_c.pop_front(); chk_word("c", ec, c_index, c_data, c_last); end
    end
    always @(negedge clk) if ((a_done && a_valid) || (b_done && b_valid) || (c_done && c_valid)) viol++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        do_preload = 1'b1;
        tick();
        do_preload = 1'b0;
    endtask

    task automatic push_full(input int r5_override, input logic [31:0] r5_val);
        word_t w;
        for (int i = 1; i <= 31; i++) begin
            w.idx  = 5'(i);
            w.data = (i == 5 && r5_override != 0) ? r5_val : 32'h1000_0000 + i;
            w.last = i == 31;
            q_a.push_back(w);
        end
    endtask

    // cycle 0 carries start; returns the cycle in which done is seen (or -1 after a reset abort)
    task automatic run_a(input int stall_idx, input int wcyc, input logic [31:0] wval,
                         input int repulse_cyc, input int reset_cyc, output int cyc);
        int stalls = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 1;
        chk("a_busy_after_start", 32'(a_busy), 1);
        chk("a_rd_reg_first", 32'(a_rd_reg), 1);
        while (cyc < 300 && !a_done) begin
            we      = cyc == wcyc;
            waddr   = 5'd5;
            wdata   = wval;
            start_a = cyc == repulse_cyc;
            ready_a = !(a_valid && 32'(a_index) == stall_idx && stalls < 5);
            if (!ready_a) begin
                stalls++;
                chk("a_stall_data", a_data, 32'h1000_0000 + stall_idx);
                chk("a_stall_index", 32'(a_index), stall_idx);
            end
            if (cyc == reset_cyc) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("a_rst_busy", 32'(a_busy), 0);
                chk("a_rst_valid", 32'(a_valid), 0);
                chk("a_rst_done", 32'(a_done), 0);
                chk("a_rst_data", a_data, 0);
                chk("a_rst_index", 32'(a_index), 0);
                cyc = -1;
                break;
            end
            tick();
            cyc++;
        end
        we = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b1;
        if (cyc > 0) chk("a_busy_at_done", 32'(a_busy), 0);
    endtask

    int cyc;

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_last", 32'(a_last), 0);
        chk("rst_data", a_data, 0);
        chk("rst_index", 32'(a_index), 0);
        chk("rst_rd_reg", 32'(a_rd_reg), 0);

        preload();
        push_full(0, 0);
        run_a(-1, -1, 0, -1, -1, cyc);
        chk("full_done_cycle", 32'(cyc), 64);
        chk("full_queue_empty", 32'(q_a.size()), 0);

        preload();
        push_full(0, 0);
        run_a(3, -1, 0, -1, -1, cyc);
        chk("stall_done_cycle", 32'(cyc), 69);
        chk("stall_queue_empty", 32'(q_a.size()), 0);

        // R5 is read in cycle 9: a write in cycle 8 lands before it, one in cycle 9 does not
        preload();
        push_full(1, 32'hDEAD_BEEF);
        run_a(-1, 8, 32'hDEAD_BEEF, -1, -1, cyc);
        chk("wr_before_done_cycle", 32'(cyc), 64);
        preload();
        push_full(0, 0);
        run_a(-1, 9, 32'hDEAD_BEEF, -1, -1, cyc);
        chk("wr_same_done_cycle", 32'(cyc), 64);

        preload();
        for (int i = 1; i <= 19; i++) q_a.push_back(word_t'{5'(i), 32'h1000_0000 + i, 1'b0});
        run_a(-1, -1, 0, 19, 39, cyc);
        chk("abort_queue_empty", 32'(q_a.size()), 0);
        tick();
        chk("abort_no_done", 32'(a_done), 0);
        push_full(0, 0);
        run_a(-1, -1, 0, -1, -1, cyc);
        chk("restart_done_cycle", 32'(cyc), 64);
        chk("restart_queue_empty", 32'(q_a.size()), 0);

        q_b.push_back(word_t'{5'd8, 32'h1000_0008, 1'b1});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_rd_reg", 32'(b_rd_reg), 8);
        cyc = 1;
        while (!b_done && cyc < 50) begin tick(); cyc++; end
        chk("b_done_cycle", 32'(cyc), 4);
        chk("b_queue_empty", 32'(q_b.size()), 0);

        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        chk("c_busy_fin", 32'(c_busy), 1);
        chk("c_valid", 32'(c_valid), 0);
        cyc = 1;
        while (!c_done && cyc < 50) begin tick(); cyc++; end
        chk("c_done_cycle", 32'(cyc), 2);
        tick();
        chk("c_done_pulse", 32'(c_done), 0);

        chk("done_valid_overlap", 32'(viol), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
